// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the stream_demux_n packet demultiplexer.
package stream_demux_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } state_e;

    // Select width never collapses to zero, even for N <= 2.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// One-deep output register slot for a single demux channel.
module stream_demux_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en_i,
    input  logic [W-1:0] data_i,
    input  logic         last_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         last_o,
    output logic         can_accept_o
);

    logic         valid_q;
    logic [W-1:0] data_q;
    logic         last_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else if (wr_en_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            last_q  <= last_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    // Draining and refilling in the same cycle keeps full throughput.
    assign can_accept_o = !valid_q || ready_i;
    assign valid_o      = valid_q;
    assign data_o       = data_q;
    assign last_o       = last_q;

endmodule

// File: rtl/stream_demux_n.sv
// 1:N packet demultiplexer: channel locked on the first beat, held until last;
// packets to nonexistent channels are discarded and counted.
module stream_demux_n
    import stream_demux_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = clog2_min1(N),
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_last,
    input  logic [SW-1:0] in_sel,
    output logic [N-1:0]  out_valid,
    input  logic [N-1:0]  out_ready,
    output logic [N*W-1:0] out_data,
    output logic [N-1:0]  out_last,
    output logic [CW-1:0] drop_cnt,
    output logic          busy
);

    state_e        state_q, state_d;
    logic [SW-1:0] lock_sel_q, lock_sel_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;

    logic [SW-1:0] tgt;
    logic          tgt_ok;
    logic          tgt_accept;
    logic          fire;
    logic [N-1:0]  can_accept;
    logic [N-1:0]  wr_en;

    // NOTE: every always_comb output gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        lock_sel_d = lock_sel_q;
        drop_cnt_d = drop_cnt_q;
        tgt        = (state_q == FWD) ? lock_sel_q : in_sel;
        tgt_ok     = (state_q == FWD) || ((state_q == IDLE) && (int'(in_sel) < N));
        tgt_accept = 1'b0;
        wr_en      = '0;

        for (int k = 0; k < N; k++) begin
            if (tgt == SW'(k)) tgt_accept = can_accept[k];
        end

        // Invalid destinations and DROP swallow beats unconditionally.
        in_ready = tgt_ok ? tgt_accept : 1'b1;
        fire     = in_valid && in_ready;

        for (int k = 0; k < N; k++) begin
            wr_en[k] = fire && tgt_ok && (tgt == SW'(k));
        end

        case (state_q)
            IDLE: begin
                if (fire) begin
                    if (tgt_ok) begin
                        if (!in_last) begin
                            state_d    = FWD;
                            lock_sel_d = in_sel;
                        end
                    end else begin
                        if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CW'(1);
                        if (!in_last) state_d = DROP;
                    end
                end
            end
            FWD, DROP: begin
                if (fire && in_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lock_sel_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_sel_q <= lock_sel_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_slot
        stream_demux_slot #(.W(W)) u_slot (
            .clk          (clk),
            .rst_n        (rst_n),
            .wr_en_i      (wr_en[k]),
            .data_i       (in_data),
            .last_i       (in_last),
            .ready_i      (out_ready[k]),
            .valid_o      (out_valid[k]),
            .data_o       (out_data[k*W +: W]),
            .last_o       (out_last[k]),
            .can_accept_o (can_accept[k])
        );
    end

    assign drop_cnt = drop_cnt_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_stream_demux_n.sv
// Directed bench for stream_demux_n: a 4-channel instance and a 3-channel
// instance with a 2-bit drop counter for the invalid-destination paths.
module tb_stream_demux_n;

    logic clk;
    logic rst_n;

    // 4-channel instance
    logic        in_valid, in_ready, in_last, busy;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic [3:0]  out_valid, out_ready, out_last;
    logic [31:0] out_data;
    logic [15:0] drop_cnt;

    // 3-channel instance
    logic        b_in_valid, b_in_ready, b_in_last, b_busy;
    logic [7:0]  b_in_data;
    logic [1:0]  b_in_sel;
    logic [2:0]  b_out_valid, b_out_ready, b_out_last;
    logic [23:0] b_out_data;
    logic [1:0]  b_drop_cnt;

    int n_vec = 0;
    int n_err = 0;

    stream_demux_n #(.N(4), .W(8), .CW(16)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .drop_cnt  (drop_cnt),
        .busy      (busy)
    );

    stream_demux_n #(.N(3), .W(8), .CW(2)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_last   (b_in_last),
        .in_sel    (b_in_sel),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .out_last  (b_out_last),
        .drop_cnt  (b_drop_cnt),
        .busy      (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0; in_data   = 8'h00; in_last   = 1'b0; in_sel   = 2'd0;
        out_ready  = 4'hF;
        b_in_valid = 1'b0; b_in_data = 8'h00; b_in_last = 1'b0; b_in_sel = 2'd0;
        b_out_ready = 3'b111;
        #3;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data",  out_data,       32'h0);
        check("rst_out_last",  32'(out_last),  32'h0);
        check("rst_drop_cnt",  32'(drop_cnt),  32'h0);
        check("rst_busy",      32'(busy),      32'h0);
        check("rst_b_drop",    32'(b_drop_cnt), 32'h0);
        #4 rst_n = 1'b1;
        tick();

        // Single-beat packet to channel 2
        in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hA5; in_last = 1'b1;
        #1 check("t1_in_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        check("t1_out_valid", 32'(out_valid),      32'h4);
        check("t1_out_data",  32'(out_data[23:16]), 32'hA5);
        check("t1_out_last",  32'(out_last[2]),     32'h1);
        check("t1_busy",      32'(busy),            32'h0);
        tick();
        check("t1_drained",   32'(out_valid),       32'h0);

        // 3-beat packet locked to channel 1 despite in_sel changing
        in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h11; in_last = 1'b0;
        #1 check("t2_busy_b1", 32'(busy), 32'h0);
        tick();
        check("t2_valid_b1", 32'(out_valid),       32'h2);
        check("t2_data_b1",  32'(out_data[15:8]),  32'h11);
        in_sel = 2'd3; in_data = 8'h22;
        #1 check("t2_busy_b2", 32'(busy), 32'h1);
        tick();
        check("t2_valid_b2", 32'(out_valid),       32'h2);
        check("t2_data_b2",  32'(out_data[15:8]),  32'h22);
        in_data = 8'h33; in_last = 1'b1;
        #1 check("t2_busy_b3", 32'(busy), 32'h1);
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        check("t2_valid_b3", 32'(out_valid),       32'h2);
        check("t2_data_b3",  32'(out_data[15:8]),  32'h33);
        check("t2_last_b3",  32'(out_last[1]),     32'h1);
        check("t2_busy_end", 32'(busy),            32'h0);
        tick();

        // Backpressure on channel 0 mid-packet
        in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h40; in_last = 1'b0;
        tick();
        check("t3_first", 32'(out_data[7:0]), 32'h40);
        out_ready[0] = 1'b0; in_data = 8'h41;
        for (int i = 0; i < 5; i++) begin
            #1 check("t3_hold_ready", 32'(in_ready),      32'h0);
            check("t3_hold_valid",    32'(out_valid[0]),  32'h1);
            check("t3_hold_data",     32'(out_data[7:0]), 32'h40);
            tick();
        end
        out_ready[0] = 1'b1;
        #1 check("t3_release_ready", 32'(in_ready), 32'h1);
        tick();
        check("t3_second", 32'(out_data[7:0]), 32'h41);
        check("t3_second_v", 32'(out_valid[0]), 32'h1);
        in_data = 8'h42; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        check("t3_third",      32'(out_data[7:0]), 32'h42);
        check("t3_third_last", 32'(out_last[0]),   32'h1);
        check("t3_busy",       32'(busy),          32'h0);
        tick();
        check("t3_drained", 32'(out_valid), 32'h0);

        // Invalid destination on the 3-channel instance, then saturation
        b_in_valid = 1'b1; b_in_sel = 2'd3; b_in_data = 8'hAA; b_in_last = 1'b0;
        #1 check("t4_ready_b1", 32'(b_in_ready), 32'h1);
        tick();
        check("t4_valid_b1", 32'(b_out_valid), 32'h0);
        check("t4_drop_b1",  32'(b_drop_cnt),  32'h1);
        check("t4_busy_b1",  32'(b_busy),      32'h1);
        b_in_sel = 2'd0; b_in_data = 8'hBB; b_in_last = 1'b1;
        #1 check("t4_ready_b2", 32'(b_in_ready), 32'h1);
        tick();
        check("t4_valid_b2", 32'(b_out_valid), 32'h0);
        check("t4_drop_b2",  32'(b_drop_cnt),  32'h1);
        check("t4_busy_b2",  32'(b_busy),      32'h0);
        b_in_data = 8'hCC;
        tick();
        check("t4_fwd_valid", 32'(b_out_valid),     32'h1);
        check("t4_fwd_data",  32'(b_out_data[7:0]), 32'hCC);
        check("t4_fwd_drop",  32'(b_drop_cnt),      32'h1);
        b_in_sel = 2'd3; b_in_data = 8'hDD;
        tick();
        check("t4_sat_2", 32'(b_drop_cnt), 32'h2);
        tick();
        check("t4_sat_3", 32'(b_drop_cnt), 32'h3);
        tick();
        check("t4_sat_hold", 32'(b_drop_cnt), 32'h3);
        b_in_valid = 1'b0; b_in_last = 1'b0;
        tick();

        // Back-to-back single-beat packets, one channel per cycle
        for (int i = 0; i < 4; i++) begin
            logic [3:0] exp_v;
            logic [7:0] exp_d;
            exp_v = 4'b0001 << i;
            exp_d = 8'h50 + 8'(i);
            in_valid = 1'b1; in_sel = 2'(i); in_data = exp_d; in_last = 1'b1;
            #1 check("t5_ready", 32'(in_ready), 32'h1);
            tick();
            check("t5_valid", 32'(out_valid),         32'(exp_v));
            check("t5_data",  32'(out_data[i*8 +: 8]), 32'(exp_d));
        end
        in_valid = 1'b0; in_last = 1'b0;
        tick();

        // Asynchronous reset mid-packet with channel 2 holding data
        out_ready[2] = 1'b0;
        in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h77; in_last = 1'b0;
        tick();
        check("t6_pre_valid", 32'(out_valid), 32'h4);
        check("t6_pre_busy",  32'(busy),      32'h1);
        in_data = 8'h78;
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(out_valid), 32'h0);
        check("t6_rst_busy",  32'(busy),      32'h0);
        check("t6_rst_bdrop", 32'(b_drop_cnt), 32'h0);
        in_valid = 1'b0; out_ready = 4'hF;
        #1 rst_n = 1'b1;
        tick();
        in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h88; in_last = 1'b0;
        tick();
        check("t6_post_valid", 32'(out_valid),        32'h4);
        check("t6_post_data",  32'(out_data[23:16]),  32'h88);
        check("t6_post_busy",  32'(busy),             32'h1);
        in_data = 8'h99; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        check("t6_post_data2", 32'(out_data[23:16]), 32'h99);
        check("t6_post_last",  32'(out_last[2]),     32'h1);
        check("t6_post_busy2", 32'(busy),            32'h0);
        check("t6_drop_cnt",   32'(drop_cnt),        32'h0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stream_demux_n.md
Name: stream_demux_n

Overview:
Parametrised 1:N packet demultiplexer, the registered and handshaked successor to the 4-way gate-level demux. Steers a valid/ready input stream to one of N output channels. The channel is chosen by in_sel on the first beat of a packet and held until the beat carrying in_last. Each channel has a 1-deep output register. Packets addressed to a nonexistent channel are dropped and counted. Sits between a packet source and N independent consumers.

Parameters:
N, 4, number of output channels (2..16)
W, 8, data width per beat
SW, $clog2(N) (min 1), select width
CW, 16, drop counter width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  reset, asynchronous, active-low; one clock domain
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
in_data  in  W  input beat payload
in_last  in  1  final beat of packet
in_sel  in  SW  destination channel; sampled only on first beat of a packet
out_valid  out  N  per-channel valid, bit k = channel k
out_ready  in  N  per-channel ready
out_data  out  N*W  channel k at [k*W +: W]
out_last  out  N  per-channel last flag
drop_cnt  out  CW  saturating count of dropped packets
busy  out  1  high while a packet is in progress (state != IDLE)

Behaviour:
- Reset (async assert, sync-safe release): state=IDLE, lock_sel=0, all out_valid=0, out_data=0, out_last=0, drop_cnt=0. in_ready is combinational and evaluates per the rules below once reset releases.
- States:
  - IDLE: no packet in progress.
  - FWD: locked to channel lock_sel.
  - DROP: discarding an invalid-destination packet.
- Target channel:
  - IDLE: tgt = in_sel.
  - FWD: tgt = lock_sel; in_sel ignored.
- Slot k can accept when !out_valid[k] || out_ready[k] (drain and refill in the same cycle is allowed).
- in_ready:
  - IDLE with in_sel < N: equals slot-accept of in_sel.
  - IDLE with in_sel >= N: 1.
  - FWD: equals slot-accept of lock_sel.
  - DROP: 1.
  - in_ready never depends on in_valid. A combinational out_ready -> in_ready path is permitted.
- Accepted beat to channel k: on the next edge, out_data[k]=in_data, out_last[k]=in_last, out_valid[k]=1. Latency is one cycle, throughput one beat per cycle.
- Slot k, no write, out_valid[k] && out_ready[k]: out_valid[k] clears. out_data and out_last hold their stale values.
- out_valid[k] and its payload stay stable while out_ready[k]=0.
- Transitions:
  - IDLE, accepted beat, in_sel < N, !in_last -> FWD, lock_sel = in_sel.
  - IDLE, accepted beat, in_sel < N, in_last -> IDLE (single-beat packet).
  - IDLE, accepted beat, in_sel >= N: drop_cnt += 1 (saturating at 2^CW-1). Next state is DROP if !in_last, else IDLE. Beat is discarded.
  - FWD, accepted beat with in_last -> IDLE.
  - DROP, accepted beat with in_last -> IDLE. No further increments for that packet.
- If N is a power of two, in_sel >= N is impossible and the DROP logic may be optimised away by synthesis. The RTL still contains it.
- Channels other than tgt keep draining independently while a packet is in progress.
- Back-to-back packets: a last beat in FWD followed next cycle by a new first beat in IDLE is accepted with no bubble.
- Reset mid-packet: all state, slots and drop_cnt clear immediately. The partial packet is lost; no recovery.

Decomposition:
- Shared package stream_demux_pkg:
  - state enum (IDLE=2'd0, FWD=2'd1, DROP=2'd2)
  - function clog2_min1 for SW
- Sub-module stream_demux_slot: 1-deep register slot with wr_en, data/last in, valid/ready out, can_accept out; async active-low reset. Instantiated N times with a generate loop.
- Top level holds the FSM, lock_sel, tgt decode, in_ready mux and drop counter.

Test Plan:
1. N=4, W=8, all out_ready=1. Single beat sel=2, data=8'hA5, last=1 -> cycle+1: out_valid=4'b0100, out_data[23:16]=8'hA5, out_last[2]=1; busy stays 0.
2. 3-beat packet sel=1 (11,22,33; last on 33), in_sel changed to 3 on beats 2-3 -> all three beats appear on channel 1 in order; channel 3 never valid; busy high for beats 2-3.
3. Backpressure: out_ready[0]=0 for 5 cycles mid-packet to channel 0 -> in_ready=0 from the cycle after the first held beat; out_data[7:0] stable; release -> remaining beats flow one per cycle, none lost or duplicated.
4. N=3, SW=2. Packet sel=3, 2 beats -> in_ready=1 throughout, no out_valid asserted, drop_cnt 0->1 after the first beat only. A following packet sel=0 is forwarded normally.
5. Back-to-back single-beat packets sel=0,1,2,3 every cycle, all ready -> one beat per cycle, out_valid one-hot sequence 0001,0010,0100,1000, no bubbles.
6. Assert rst_n=0 mid-packet with channel 2 holding valid data -> out_valid=0 and busy=0 immediately (asynchronous). After release, a new packet sel=2 forwards correctly; drop_cnt=0.
